// File: rtl/lod_share_arbiter.sv
// Round-robin shared leading-one-detect / normalize unit for NUM_REQ requesters.
// Accepts one operand per cycle. The result sits in a single-entry valid/ready register tagged with the requester id.
module lod_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_W-1:0]       out_id,
    output logic [4:0]            out_index,
    output logic                  out_zero,
    output logic [31:0]           out_norm,
    output logic                  busy
);

    logic [ID_W-1:0]    last_grant_reg, last_grant_next;
    logic               out_valid_reg, out_valid_next;
    logic [ID_W-1:0]    out_id_reg, out_id_next;
    logic [4:0]         out_index_reg, out_index_next;
    logic               out_zero_reg, out_zero_next;
    logic [31:0]        out_norm_reg, out_norm_next;

    logic [31:0]        operand [NUM_REQ];
    logic [NUM_REQ-1:0] above_last;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] search_vec;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_id;
    logic               can_accept;
    logic               transfer;
    logic [31:0]        sel_data;
    logic [31:0]        lod_work;
    logic [4:0]         lz;
    logic               lod_zero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            localparam logic [ID_W-1:0] GI_ID = ID_W'(gi);
            assign operand[gi]    = req_data[32*gi +: 32];
            assign above_last[gi] = (GI_ID > last_grant_reg);
        end
    endgenerate

    // Requests above the pointer win; otherwise wrap around to the lowest valid index.
    assign can_accept   = ~out_valid_reg | out_ready;
    assign req_hi       = req_valid & above_last;
    assign search_vec   = (|req_hi) ? req_hi : req_valid;
    assign grant_onehot = can_accept ? (search_vec & (~search_vec + NUM_REQ'(1))) : '0;
    assign req_ready    = rst_n ? grant_onehot : '0;
    assign transfer     = |(grant_onehot & req_valid);

    always_comb begin
        grant_id = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                grant_id = ID_W'(i);
                sel_data = operand[i];
            end
        end
    end

    // Binary search: each stage shifts when the upper half of the remaining window is empty.
    always_comb begin
        lod_work = sel_data;
        lz       = '0;
        if (lod_work[31:16] == 16'd0) begin
            lz[4]    = 1'b1;
            lod_work = lod_work << 16;
        end
        if (lod_work[31:24] == 8'd0) begin
            lz[3]    = 1'b1;
            lod_work = lod_work << 8;
        end
        if (lod_work[31:28] == 4'd0) begin
            lz[2]    = 1'b1;
            lod_work = lod_work << 4;
        end
        if (lod_work[31:30] == 2'd0) begin
            lz[1]    = 1'b1;
            lod_work = lod_work << 2;
        end
        if (lod_work[31] == 1'b0) begin
            lz[0]    = 1'b1;
            lod_work = lod_work << 1;
        end
        lod_zero = (sel_data == 32'd0);
    end

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_id_next     = out_id_reg;
        out_index_next  = out_index_reg;
        out_zero_next   = out_zero_reg;
        out_norm_next   = out_norm_reg;
        last_grant_next = last_grant_reg;
        if (transfer) begin
            out_valid_next  = 1'b1;
            out_id_next     = grant_id;
            out_index_next  = lod_zero ? 5'd0 : (5'd31 - lz);
            out_zero_next   = lod_zero;
            out_norm_next   = lod_zero ? 32'd0 : lod_work;
            last_grant_next = grant_id;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_id_reg     <= '0;
            out_index_reg  <= '0;
            out_zero_reg   <= 1'b0;
            out_norm_reg   <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            out_valid_reg  <= out_valid_next;
            out_id_reg     <= out_id_next;
            out_index_reg  <= out_index_next;
            out_zero_reg   <= out_zero_next;
            out_norm_reg   <= out_norm_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_index = out_index_reg;
    assign out_zero  = out_zero_reg;
    assign out_norm  = out_norm_reg;
    assign busy      = out_valid_reg & ~out_ready;

endmodule

// File: tb/tb_lod_share_arbiter.sv
// Bench for lod_share_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_lod_share_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IDW-1:0]  out_id;
    logic [4:0]      out_index;
    logic            out_zero;
    logic [31:0]     out_norm;
    logic            busy;

    lod_share_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_index(out_index), .out_zero(out_zero), .out_norm(out_norm), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid, nx_valid;
    int          m_id, nx_id;
    int          m_index, nx_index;
    logic        m_zero, nx_zero;
    logic [31:0] m_norm, nx_norm;
    int          m_last, nx_last;

    function automatic int pick(input int last, input logic [N-1:0] v, input logic free);
        if (!free) return -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int msb_pos(input logic [31:0] d);
        for (int b = 31; b >= 0; b--) if (d[b]) return b;
        return 0;
    endfunction

    function automatic int enc(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_id = 0; m_index = 0; m_zero = 1'b0; m_norm = '0; m_last = N - 1;
        end else begin
            m_valid = nx_valid; m_id = nx_id; m_index = nx_index;
            m_zero = nx_zero; m_norm = nx_norm; m_last = nx_last;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_norm", out_norm, 0);
            nx_valid = 1'b0; nx_id = 0; nx_index = 0; nx_zero = 1'b0; nx_norm = '0; nx_last = N - 1;
        end else begin
            int g;
            logic [N-1:0] exp_ready;
            logic [31:0] d;
            g = pick(m_last, req_valid, !m_valid || out_ready);
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            chk("out_valid", out_valid, m_valid);
            chk("out_id", out_id, m_id);
            chk("out_index", out_index, m_index);
            chk("out_zero", out_zero, m_zero);
            chk("out_norm", out_norm, m_norm);
            chk("busy", busy, m_valid && !out_ready);
            nx_valid = m_valid; nx_id = m_id; nx_index = m_index;
            nx_zero = m_zero; nx_norm = m_norm; nx_last = m_last;
            if (g >= 0) begin
                d = req_data[32*g +: 32];
                nx_valid = 1'b1;
                nx_id    = g;
                nx_zero  = (d == 0);
                nx_index = msb_pos(d);
                nx_norm  = (d == 0) ? 32'd0 : (d << (31 - msb_pos(d)));
                nx_last  = g;
            end else if (out_ready) begin
                nx_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] sweep_data [4];
        int          sweep_idx  [4];
        logic [31:0] sweep_norm [4];
        int          rr_order   [6];
        logic [N-1:0] acc;
        sweep_data = '{32'h0000_0010, 32'h8000_0000, 32'h0001_2345, 32'h0000_0000};
        sweep_idx  = '{4, 31, 16, 0};
        sweep_norm = '{32'h8000_0000, 32'h8000_0000, 32'h91A2_8000, 32'h0000_0000};
        rr_order   = '{0, 1, 2, 3, 0, 1};

        repeat (3) step();
        rst_n = 1'b1;
        probe();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_id", out_id, 0);

        // Single request from requester 0
        step();
        req_valid = 4'b0001; req_data[31:0] = 32'h0000_0001; out_ready = 1'b1;
        probe();
        chk("single_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        probe();
        chk("single_valid", out_valid, 1);
        chk("single_id", out_id, 0);
        chk("single_index", out_index, 0);
        chk("single_zero", out_zero, 0);
        chk("single_norm", out_norm, 32'h8000_0000);

        // Datapath sweep on requester 2, back to back
        step();
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                req_valid = 4'b0100;
                req_data[64 +: 32] = sweep_data[k];
            end else begin
                req_valid = '0;
            end
            probe();
            if (k < 4) chk("sweep_ready", req_ready, 4'b0100);
            if (k > 0) begin
                chk("sweep_id", out_id, 2);
                chk("sweep_index", out_index, sweep_idx[k-1]);
                chk("sweep_norm", out_norm, sweep_norm[k-1]);
                chk("sweep_zero", out_zero, (k == 4));
            end
            step();
        end

        // Round robin from a fresh reset
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        req_data = {32'h0000_0008, 32'h0000_0004, 32'h0000_0002, 32'h0000_0001};
        for (int c = 0; c < 6; c++) begin
            probe();
            chk("rr_grant", enc(req_ready), rr_order[c]);
            if (c >= 1) chk("rr_out_valid", out_valid, 1);
            step();
        end

        // Skip idle requesters: pointer now at 1
        req_valid = 4'b1001;
        req_data[96 +: 32] = 32'hFFFF_FFFF;
        req_data[0 +: 32]  = 32'h0000_0300;
        probe();
        chk("skip_grant3", req_ready, 4'b1000);
        step();
        probe();
        chk("skip_grant0", req_ready, 4'b0001);
        chk("skip_id3", out_id, 3);
        chk("skip_index3", out_index, 31);
        step();

        // Backpressure with requester 0's result pending
        out_ready = 1'b0;
        req_valid = 4'b0011;
        for (int s = 0; s < 3; s++) begin
            probe();
            chk("stall_ready", req_ready, 4'b0000);
            chk("stall_valid", out_valid, 1);
            chk("stall_busy", busy, 1);
            chk("stall_id", out_id, 0);
            chk("stall_index", out_index, 9);
            chk("stall_norm", out_norm, 32'hC000_0000);
            step();
        end
        out_ready = 1'b1;
        probe();
        chk("release_grant", req_ready, 4'b0010);
        step();

        // Asynchronous reset while a result is held
        probe();
        chk("pre_reset_valid", out_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_drop_valid", out_valid, 0);
        chk("async_ready_low", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        probe();
        chk("post_reset_grant", req_ready, 4'b0001);
        step();

        // Randomized traffic; requesters hold until accepted
        req_valid = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            probe();
            acc = req_valid & req_ready;
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 55);
                    case ($urandom_range(0, 9))
                        0:       req_data[32*i +: 32] = 32'd0;
                        1:       req_data[32*i +: 32] = 32'd1 << $urandom_range(0, 31);
                        default: req_data[32*i +: 32] = $urandom >> $urandom_range(0, 31);
                    endcase
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
        end

        probe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
